// File: rtl/vga_timing_gen_if.sv
// Pixel-stream bundle passed along the drawing chain: position, sync/blank flags and colour.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport vga_out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport vga_in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_timing_gen.sv
// Head of the pixel stream: raster counters with registered sync/blank decode and a
// per-frame start pulse. Colour is left black for later stages to paint over.
module vga_timing_gen #(
  parameter int H_ACTIVE     = 800,
  parameter int H_SYNC_START = 840,
  parameter int H_SYNC_LEN   = 128,
  parameter int H_TOTAL      = 1056,
  parameter int V_ACTIVE     = 600,
  parameter int V_SYNC_START = 601,
  parameter int V_SYNC_LEN   = 4,
  parameter int V_TOTAL      = 628,
  parameter int SYNC_POL     = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   pix_en,
  vga_if.vga_out vga_out,
  output logic   frame_start
);

  if (H_TOTAL > 2048 || V_TOTAL > 2048 ||
      H_ACTIVE > H_SYNC_START || H_SYNC_START + H_SYNC_LEN > H_TOTAL ||
      V_ACTIVE > V_SYNC_START || V_SYNC_START + V_SYNC_LEN > V_TOTAL) begin : g_bad_params
    $fatal(1, "vga_timing_gen: inconsistent timing parameters");
  end

  localparam logic [10:0] H_ACT = 11'(H_ACTIVE);
  localparam logic [10:0] H_SS  = 11'(H_SYNC_START);
  localparam logic [11:0] H_SE  = 12'(H_SYNC_START + H_SYNC_LEN);
  localparam logic [10:0] H_MAX = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_ACT = 11'(V_ACTIVE);
  localparam logic [10:0] V_SS  = 11'(V_SYNC_START);
  localparam logic [11:0] V_SE  = 12'(V_SYNC_START + V_SYNC_LEN);
  localparam logic [10:0] V_MAX = 11'(V_TOTAL - 1);
  localparam logic        POL   = (SYNC_POL != 0);

  logic [10:0] hcount, vcount, hnext, vnext;
  logic        hsync, vsync, hblnk, vblnk;
  logic        wrap;

  always_comb begin
    hnext = hcount + 11'd1;
    vnext = vcount;
    wrap  = 1'b0;
    if (hcount == H_MAX) begin
      hnext = '0;
      if (vcount == V_MAX) begin
        vnext = '0;
        wrap  = 1'b1;
      end else begin
        vnext = vcount + 11'd1;
      end
    end
  end

  // Flags are decoded from the next position so they land in the same cycle as it.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount      <= '0;
      vcount      <= '0;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      hsync       <= ~POL;
      vsync       <= ~POL;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      hcount      <= hnext;
      vcount      <= vnext;
      hblnk       <= (hnext >= H_ACT);
      vblnk       <= (vnext >= V_ACT);
      hsync       <= (hnext >= H_SS && {1'b0, hnext} < H_SE) ? POL : ~POL;
      vsync       <= (vnext >= V_SS && {1'b0, vnext} < V_SE) ? POL : ~POL;
      frame_start <= wrap;
    end else begin
      frame_start <= 1'b0;
    end
  end

  assign vga_out.hcount = hcount;
  assign vga_out.vcount = vcount;
  assign vga_out.hsync  = hsync;
  assign vga_out.vsync  = vsync;
  assign vga_out.hblnk  = hblnk;
  assign vga_out.vblnk  = vblnk;
  assign vga_out.rgb    = 12'h000;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Source end of the vga_if pixel stream: generates hcount/vcount, hsync/vsync and hblnk/vblnk.
- Feeds the first drawing stage of the chain (background, wind bar, sprites).
- Default timing is 800x600 @ 60 Hz at a 40 MHz pixel clock.
- Drives rgb to black; downstream stages paint over it.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_SYNC_START, 840, first hcount with hsync asserted
- H_SYNC_LEN, 128, hsync width in pixels
- H_TOTAL, 1056, pixels per line (hcount wraps at H_TOTAL-1)
- V_ACTIVE, 600, visible lines per frame
- V_SYNC_START, 601, first vcount with vsync asserted
- V_SYNC_LEN, 4, vsync width in lines
- V_TOTAL, 628, lines per frame (vcount wraps at V_TOTAL-1)
- SYNC_POL, 1, sync asserted level (1 = active-high, 0 = active-low)

Ports:
- clk  input  1  pixel clock
- rst  input  1  synchronous, active-high reset
- pix_en  input  1  advance enable; counters step only when 1
- vga_out  output  vga_if.vga_out modport  hcount[10:0], vcount[10:0], hsync, vsync, hblnk, vblnk, rgb[11:0]
- frame_start  output  1  one-cycle pulse marking the first pixel (0,0) of each frame

Behaviour:
- Reset (rst=1, synchronous, active-high; clock clk): on the next edge the outputs take these values.
  - hcount=0, vcount=0, hblnk=0, vblnk=0.
  - hsync=vsync=~SYNC_POL, i.e. the inactive level.
  - rgb=0, frame_start=0.
  - These are exactly the decoded values for position (0,0).
  - Reset mid-frame aborts the frame immediately; there is no residual state.
- All outputs are registered: each cycle, compute the next position and its decode, then register them. There is no combinational path from inputs to outputs.
- Position advance happens on an edge with rst=0 and pix_en=1:
  - hcount < H_TOTAL-1: hcount+1, vcount unchanged.
  - hcount = H_TOTAL-1: hcount=0.
    - If vcount < V_TOTAL-1: vcount+1.
    - Otherwise vcount=0 (frame wrap).
- pix_en=0: all outputs hold their values; frame_start is forced to 0.
- Decode is applied to the registered position, so flags are always consistent with the hcount/vcount shown on the same cycle:
  - hblnk = (hcount >= H_ACTIVE)
  - vblnk = (vcount >= V_ACTIVE)
  - hsync = SYNC_POL when H_SYNC_START <= hcount < H_SYNC_START+H_SYNC_LEN, else ~SYNC_POL
  - vsync = SYNC_POL when V_SYNC_START <= vcount < V_SYNC_START+V_SYNC_LEN, else ~SYNC_POL
  - The vertical flags change only together with vcount, i.e. at a line wrap.
  - rgb = 12'h000 at all times.
- frame_start:
  - Is 1 for exactly the cycle in which the outputs step from (H_TOTAL-1, V_TOTAL-1) to (0,0).
  - Is not asserted for the (0,0) state produced by reset.
  - Consumers use it to latch per-frame state, e.g. wind value or sprite positions.
- Width rules:
  - Counters are 11-bit unsigned.
  - Comparisons are unsigned on the 11-bit values.
  - Sync end is computed at elaboration in 12 bits.
- Elaboration constraints, enforced by assertion:
  - H_TOTAL <= 2048 and V_TOTAL <= 2048.
  - H_ACTIVE <= H_SYNC_START.
  - H_SYNC_START+H_SYNC_LEN <= H_TOTAL.
  - The same relations hold for the vertical parameters.
- Latency: one cycle from a pix_en=1 edge to the updated outputs. Steady state gives one pixel per enabled cycle, 1056*628 = 663168 enabled cycles per frame.

Test Plan:
- Reset values: hold rst=1 for 3 cycles with pix_en=1, then release. During reset outputs read (0,0), hblnk=vblnk=0, hsync=vsync=0, frame_start=0. The first enabled edge after release gives hcount=1.
- Line wrap and hsync: run from (0,0).
  - hblnk rises at hcount=800.
  - hsync=1 for hcount 840..967 and 0 at 968.
  - At hcount=1055 -> 0, vcount goes 0 -> 1.
- Frame wrap and vsync:
  - vblnk=1 for vcount 600..627.
  - vsync=1 only for vcount 601..604.
  - Step (1055,627) -> (0,0) pulses frame_start for exactly one cycle.
  - Exactly 663168 enabled cycles between frame_start pulses.
- pix_en gating: toggle pix_en 1,0,0,1 at hcount=500. Output holds at 501 for 2 cycles, then goes to 502. Repeat at (1055,627) with pix_en low: frame_start stays 0 until the enabled step.
- Reset mid-frame: assert rst at (400,300). Next edge gives (0,0) with flags deasserted and no frame_start pulse. The subsequent frame timing is identical to the first.
- Polarity: with SYNC_POL=0, reset gives hsync=vsync=1, and hsync=0 only for hcount 840..967.
